// File: rtl/tcm_dec_hd_frame_ctrl.sv
//-----------------------------------------------------------------------------
// tcm_dec_hd_frame_ctrl
//
// Frame sequencer for the 4D-8PSK TCM decoder hard-decision path. A start
// command streams one frame of 4D symbol metrics out of the metric buffer RAM
// (one read per enabled clock unless the source stalls). The RAM data port
// feeds the TMU hard-decision unit directly. The 8-bit decisions coming back
// are written in order into the HD output RAM, and completion is signalled
// with a one-clock odone pulse.
//
// Parameters
//   pADDR_W  frame address width; longest frame is 2^pADDR_W-1 symbols
//   pRD_LAT  metric RAM read latency in enabled clocks (1..4)
//   pHD_LAT  hard-decision unit latency, ival -> oval, in enabled clocks
//
// Ports
//   iclk, ireset   clock; asynchronous active-high reset
//   iclkena        global clock enable; low freezes every flop in the block
//   istart, ilen   frame start request and length (only sampled in IDLE)
//   ihold          source stall; blocks new metric reads while high
//   obusy, odone   frame in progress / one-clock completion pulse
//   ordena/ordaddr metric RAM read strobe and address
//   ohd_ival       valid to the HD unit (ordena delayed by pRD_LAT)
//   ihd_oval, ihd  HD unit output valid and decision word {s3,s2,s1,s0}
//   owrite/owaddr/owdat  HD output RAM write port
//-----------------------------------------------------------------------------
module tcm_dec_hd_frame_ctrl #(
  parameter int pADDR_W = 8,
  parameter int pRD_LAT = 1,
  parameter int pHD_LAT = 2
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pADDR_W-1:0] ilen,
  input  logic               ihold,
  output logic               obusy,
  output logic               odone,
  output logic               ordena,
  output logic [pADDR_W-1:0] ordaddr,
  output logic               ohd_ival,
  input  logic               ihd_oval,
  input  logic [7:0]         ihd,
  output logic               owrite,
  output logic [pADDR_W-1:0] owaddr,
  output logic [7:0]         owdat
);

  // Elaboration-time guard: the read delay line is sized by pRD_LAT and the
  // DRAIN exit assumes the last write trails the last read.
  if (pRD_LAT < 1 || pRD_LAT > 4 || pHD_LAT < 0 || pADDR_W < 1) begin : g_bad_param
    $error("tcm_dec_hd_frame_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [pADDR_W-1:0] cCNT_ONE = pADDR_W'(1);

  state_t               state_q,  state_d;
  logic [pADDR_W-1:0]   len_q,    len_d;
  logic [pADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [pADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [pRD_LAT-1:0]   rd_vld_q, rd_vld_d;

  logic                 rd_en;
  logic                 wr_en;

  //---------------------------------------------------------------------------
  // Next-state / output logic
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rd_en    = 1'b0;

    // Write path. Decisions arriving once the frame is complete (or after an
    // abort, while idle) are stale and must not reach the output RAM.
    wr_en = ihd_oval && (state_q != ST_IDLE) && (wr_cnt_q != len_q);
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + cCNT_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (istart) begin
          len_d    = ilen;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (ilen == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (!ihold) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + cCNT_ONE;
          if (rd_cnt_q == (len_q - cCNT_ONE)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Use the post-write count so DONE follows the last write directly
        // instead of one clock later.
        if (wr_cnt_d == len_q) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Read-valid delay line: bit 0 is the newest read, MSB lines up with the
    // RAM data reaching the HD unit.
    rd_vld_d = (rd_vld_q << 1) | pRD_LAT'(rd_en);
  end

  //---------------------------------------------------------------------------
  // State registers
  //---------------------------------------------------------------------------
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      // NOTE: the read-valid delay line is a handful of flops, not a memory,
      // so it is reset with the rest; an abort must not leave a valid in
      // flight toward the HD unit.
      rd_vld_q <= '0;
    end else if (iclkena) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  //---------------------------------------------------------------------------
  // Outputs
  //---------------------------------------------------------------------------
  assign obusy    = (state_q != ST_IDLE);
  assign odone    = (state_q == ST_DONE);
  assign ordena   = rd_en;
  assign ordaddr  = rd_cnt_q;
  assign ohd_ival = rd_vld_q[pRD_LAT-1];
  assign owrite   = wr_en;
  assign owaddr   = wr_cnt_q;
  // Data is masked when not writing so the port idles at zero.
  assign owdat    = wr_en ? ihd : 8'h00;

endmodule

// File: tb/tb_tcm_dec_hd_frame_ctrl.sv
//-----------------------------------------------------------------------------
// Testbench for tcm_dec_hd_frame_ctrl.
// Two instances: u_dut_a with default parameters (8/1/2) and u_dut_b with
// pADDR_W=4, pRD_LAT=3 for the maximum-length frame. Each has a RAM + HD unit
// model returning ihd = read address ^ 8'hA5. Stimulus pushes expected reads,
// writes and odone pulses into queues; a monitor on the falling edge pops and
// compares whenever a DUT presents an enabled strobe.
//-----------------------------------------------------------------------------
module tb_tcm_dec_hd_frame_ctrl;

  localparam int A_RD = 1;
  localparam int A_HD = 2;
  localparam int B_RD = 3;
  localparam int B_HD = 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         cyc;   // expected cycle index, -1 = untimed
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkena = 1'b1;
  int   cyc = 0;

  // instance A
  logic       istart_a = 1'b0;
  logic [7:0] ilen_a = '0;
  logic       ihold_a = 1'b0;
  logic       obusy_a, odone_a, ordena_a, ohd_ival_a, owrite_a;
  logic [7:0] ordaddr_a, owaddr_a, owdat_a;
  logic       hd_oval_a;
  logic [7:0] hd_a;

  // instance B
  logic       istart_b = 1'b0;
  logic [3:0] ilen_b = '0;
  logic       ihold_b = 1'b0;
  logic       obusy_b, odone_b, ordena_b, ohd_ival_b, owrite_b;
  logic [3:0] ordaddr_b, owaddr_b;
  logic [7:0] owdat_b;
  logic       hd_oval_b;
  logic [7:0] hd_b;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t done_q[$];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcm_dec_hd_frame_ctrl #(.pADDR_W(8), .pRD_LAT(A_RD), .pHD_LAT(A_HD)) u_dut_a (
    .iclk(clk), .ireset(rst), .iclkena(clkena),
    .istart(istart_a), .ilen(ilen_a), .ihold(ihold_a),
    .obusy(obusy_a), .odone(odone_a),
    .ordena(ordena_a), .ordaddr(ordaddr_a), .ohd_ival(ohd_ival_a),
    .ihd_oval(hd_oval_a), .ihd(hd_a),
    .owrite(owrite_a), .owaddr(owaddr_a), .owdat(owdat_a)
  );

  tcm_dec_hd_frame_ctrl #(.pADDR_W(4), .pRD_LAT(B_RD), .pHD_LAT(B_HD)) u_dut_b (
    .iclk(clk), .ireset(rst), .iclkena(clkena),
    .istart(istart_b), .ilen(ilen_b), .ihold(ihold_b),
    .obusy(obusy_b), .odone(odone_b),
    .ordena(ordena_b), .ordaddr(ordaddr_b), .ohd_ival(ohd_ival_b),
    .ihd_oval(hd_oval_b), .ihd(hd_b),
    .owrite(owrite_b), .owaddr(owaddr_b), .owdat(owdat_b)
  );

  //---------------------------------------------------------------------------
  // RAM + HD unit models (share reset and clock enable with the DUTs)
  //---------------------------------------------------------------------------
  logic [7:0] ram_a_a [A_RD];
  logic       hd_v_a  [A_HD];
  logic [7:0] hd_d_a  [A_HD];
  logic [3:0] ram_a_b [B_RD];
  logic       hd_v_b  [B_HD];
  logic [7:0] hd_d_b  [B_HD];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A_RD; i++) ram_a_a[i] <= '0;
      for (int i = 0; i < A_HD; i++) begin hd_v_a[i] <= 1'b0; hd_d_a[i] <= '0; end
      for (int i = 0; i < B_RD; i++) ram_a_b[i] <= '0;
      for (int i = 0; i < B_HD; i++) begin hd_v_b[i] <= 1'b0; hd_d_b[i] <= '0; end
    end else if (clkena) begin
      ram_a_a[0] <= ordaddr_a;
      for (int i = 1; i < A_RD; i++) ram_a_a[i] <= ram_a_a[i-1];
      hd_v_a[0] <= ohd_ival_a;
      hd_d_a[0] <= ram_a_a[A_RD-1] ^ 8'hA5;
      for (int i = 1; i < A_HD; i++) begin hd_v_a[i] <= hd_v_a[i-1]; hd_d_a[i] <= hd_d_a[i-1]; end
      ram_a_b[0] <= ordaddr_b;
      for (int i = 1; i < B_RD; i++) ram_a_b[i] <= ram_a_b[i-1];
      hd_v_b[0] <= ohd_ival_b;
      hd_d_b[0] <= {4'h0, ram_a_b[B_RD-1]} ^ 8'hA5;
      for (int i = 1; i < B_HD; i++) begin hd_v_b[i] <= hd_v_b[i-1]; hd_d_b[i] <= hd_d_b[i-1]; end
    end
  end

  assign hd_oval_a = hd_v_a[A_HD-1];
  assign hd_a      = hd_d_a[A_HD-1];
  assign hd_oval_b = hd_v_b[B_HD-1];
  assign hd_b      = hd_d_b[B_HD-1];

  //---------------------------------------------------------------------------
  // Checking helpers
  //---------------------------------------------------------------------------
  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) @cyc %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic sb_rd(input logic [7:0] a);
    ev_t e;
    if (rd_q.size() == 0) begin
      n_total++;
      $display("FAIL rd_unexpected: read addr 0x%0h with none pending @cyc %0d", a, cyc);
    end else begin
      e = rd_q.pop_front();
      check("rd_addr", a, e.a);
      if (e.cyc >= 0) check("rd_cycle", cyc, e.cyc);
    end
  endtask

  task automatic sb_wr(input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    if (wr_q.size() == 0) begin
      n_total++;
      $display("FAIL wr_unexpected: write addr 0x%0h data 0x%0h with none pending @cyc %0d", a, d, cyc);
    end else begin
      e = wr_q.pop_front();
      check("wr_addr", a, e.a);
      check("wr_data", d, e.d);
      if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
    end
  endtask

  task automatic sb_done();
    ev_t e;
    if (done_q.size() == 0) begin
      n_total++;
      $display("FAIL done_unexpected: odone with none pending @cyc %0d", cyc);
    end else begin
      e = done_q.pop_front();
      if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: only enabled clocks count as events.
  always @(negedge clk) begin
    if (!rst && clkena) begin
      if (ordena_a) sb_rd(ordaddr_a);
      if (owrite_a) sb_wr(owaddr_a, owdat_a);
      if (odone_a)  sb_done();
      if (ordena_b) sb_rd({4'h0, ordaddr_b});
      if (owrite_b) sb_wr({4'h0, owaddr_b}, owdat_b);
      if (odone_b)  sb_done();
    end
  end

  //---------------------------------------------------------------------------
  // Stimulus helpers
  //---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected events for a whole frame started in cycle s.
  task automatic exp_frame(input int len, input int s, input int rd_lat,
                           input int hd_lat, input bit timed);
    for (int i = 0; i < len; i++) begin
      rd_q.push_back('{a: 8'(i), d: 8'h00, cyc: timed ? s + 1 + i : -1});
      wr_q.push_back('{a: 8'(i), d: 8'(i) ^ 8'hA5,
                       cyc: timed ? s + 1 + rd_lat + hd_lat + i : -1});
    end
    done_q.push_back('{a: 8'h00, d: 8'h00,
                       cyc: !timed ? -1 : (len == 0) ? s + 1 : s + len + rd_lat + hd_lat + 1});
  endtask

  task automatic start_a(input int len);
    exp_frame(len, cyc, A_RD, A_HD, 1'b1);
    istart_a = 1'b1;
    ilen_a   = 8'(len);
    tick();
    istart_a = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int budget);
    for (int n = 0; n < budget && (obusy_a || obusy_b); n++) tick();
    check({name, "_busy_low"}, obusy_a | obusy_b, 0);
    check({name, "_rd_left"}, rd_q.size(), 0);
    check({name, "_wr_left"}, wr_q.size(), 0);
    check({name, "_done_left"}, done_q.size(), 0);
  endtask

  //---------------------------------------------------------------------------
  // Directed tests
  //---------------------------------------------------------------------------
  initial begin
    int s;

    // Reset state
    #2;
    check("rst_obusy", obusy_a, 0);
    check("rst_odone", odone_a, 0);
    check("rst_ordena", ordena_a, 0);
    check("rst_ordaddr", ordaddr_a, 0);
    check("rst_ohd_ival", ohd_ival_a, 0);
    check("rst_owrite", owrite_a, 0);
    check("rst_owaddr", owaddr_a, 0);
    check("rst_owdat", owdat_a, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic frame, len=5: reads 0..4, writes A5,A4,A7,A6,A1 from s+4
    start_a(5);
    wait_frame("basic", 100);
    tick();

    // Zero length: no reads/writes, odone one cycle after the start cycle
    start_a(0);
    wait_frame("zero", 20);
    tick();

    // Stalls: ihold for 3 cycles after the 2nd read, clkena low every 3rd cycle
    exp_frame(8, cyc, A_RD, A_HD, 1'b0);
    ilen_a = 8'd8;
    for (int k = 0; k < 300; k++) begin
      clkena   = (k % 3 != 2);
      ihold_a  = (k >= 4 && k <= 6);
      istart_a = (k == 0);
      tick();
      if (k > 1 && !obusy_a) break;
    end
    clkena  = 1'b1;
    ihold_a = 1'b0;
    istart_a = 1'b0;
    wait_frame("stall", 20);
    tick();

    // Start collision: re-starts in RUN and DRAIN are ignored
    s = cyc;
    start_a(6);              // now in cycle s+1
    tick();                  // cycle s+2, RUN
    istart_a = 1'b1; ilen_a = 8'd2;
    tick();
    istart_a = 1'b0;
    repeat (5) tick();       // cycle s+8, DRAIN
    check("coll_drain_busy", obusy_a, 1);
    check("coll_drain_noread", ordena_a, 0);
    istart_a = 1'b1; ilen_a = 8'd3;
    tick();
    istart_a = 1'b0;
    wait_frame("coll", 50);
    start_a(2);              // accepted right after returning to IDLE
    wait_frame("coll_next", 50);
    tick();

    // Reset mid-RUN with len=10 after 4 reads
    s = cyc;
    for (int i = 0; i < 4; i++)
      rd_q.push_back('{a: 8'(i), d: 8'h00, cyc: s + 1 + i});
    wr_q.push_back('{a: 8'h00, d: 8'hA5, cyc: s + 4});
    istart_a = 1'b1; ilen_a = 8'd10;
    tick();
    istart_a = 1'b0;
    repeat (3) tick();       // cycle s+4: read 3 and write 0 in flight
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_obusy", obusy_a, 0);
    check("abort_odone", odone_a, 0);
    check("abort_ordena", ordena_a, 0);
    check("abort_ordaddr", ordaddr_a, 0);
    check("abort_ohd_ival", ohd_ival_a, 0);
    check("abort_owrite", owrite_a, 0);
    check("abort_owaddr", owaddr_a, 0);
    tick();
    check("abort_idle_next_edge", obusy_a, 0);
    rst = 1'b0;
    repeat (6) tick();       // any owrite/odone here shows up as unexpected
    check("abort_rd_left", rd_q.size(), 0);
    check("abort_wr_left", wr_q.size(), 0);
    start_a(3);
    wait_frame("after_abort", 50);
    tick();

    // Max length on instance B: len=15, first write 6 cycles after start
    exp_frame(15, cyc, B_RD, B_HD, 1'b1);
    istart_b = 1'b1;
    ilen_b   = 4'd15;
    tick();
    istart_b = 1'b0;
    check("max_busy", obusy_b, 1);
    wait_frame("max", 100);
    check("max_obusy_a_quiet", obusy_a, 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
